counter_poll_reader: RTL and testbench
======================================

// Module: counter_poll_reader
// PURPOSE
//  Requesting end of the counter read-out interface (req/idx -> counter_out/valid_out).
//  On a start pulse it polls all four per-FIFO push counters in order idx 3,2,1,0.
//  It waits for system idle before each request and latches each returned count into a snapshot register.
//  Sits between the top-level control FSM and the counter block, so software and the bench read one coherent snapshot.
// PARAMETERS
//  CBITS      5  width of counter_out and of each snapshot
//  TIMEOUT    4  consecutive WAIT cycles without valid_out before a retry (must be >=2)
//  MAX_RETRY  2  retries per index before error is flagged
// PORTS
//  clk          in   1      single clock, all state on posedge
//  reset        in   1      asynchronous, active-low; 0 = in reset
//  start        in   1      1-cycle request to take a snapshot; ignored while busy=1
//  idle         in   1      system idle; a req is issued only when idle=1
//  counter_out  in   CBITS  count returned by counter block
//  valid_out    in   1      counter_out valid this cycle
//  req          out  1      read request to counter block, registered, 1-cycle pulse
//  idx          out  2      counter index for req, registered
//  snap0..snap3 out  CBITS  latched counts for FIFO0..FIFO3
//  snap_valid   out  1      all four snaps captured without error
//  busy         out  1      FSM not in IDLE_S
//  done         out  1      1-cycle pulse at end of poll (success or error)
//  error        out  1      some index exhausted MAX_RETRY; sticky until next start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE_S; req=0; idx=0; snap0..3=0; snap_valid=0; busy=0; done=0; error=0; counters=0.
//  IDLE_S:
//   - start=1 -> REQ_S, cur=3, clear snap_valid, error and retry count.
//  REQ_S:
//   - idle=1 -> req<=1, idx<=cur, wait count<=0, -> WAIT_S.
//   - idle=0 -> stay in REQ_S, req stays 0. No timeout here.
//  WAIT_S:
//   - req is cleared on the first edge.
//   - valid_out=1 -> snap[cur]<=counter_out, retry count<=0.
//     cur==0 -> DONE_S; else cur-1 -> REQ_S.
//   - valid_out=0 -> wait count+1. At TIMEOUT, go to REQ_S and retry count+1.
//     A retry with retry count==MAX_RETRY instead sets error=1 and goes to DONE_S.
//  DONE_S: done=1 for exactly one cycle; snap_valid<=!error; -> IDLE_S.
//  Polling stops at the first failing index. Earlier snaps keep their new values; later snaps keep their old values.
//  valid_out outside WAIT_S is ignored.
//  Snaps change only on a capture; they hold between polls.
//  Latency: idle held 1, responder registers its reply on the edge sampling req.
//   - req rises after edge 1 (edge 0 samples start). Each index costs 3 edges.
//   - done=1 after edge 12; busy=0 after edge 13.
//  Simultaneous start and DONE_S: start is ignored (busy=1).
//  counter_out is captured as-is. Wrap-around of the count is the counter block's concern.
//  Reset mid-poll aborts at once: all outputs return to reset values and no partial snapshot is kept.
// CONFIGURATION
//  READER_TOTAL_EN defined:
//   - adds output total [CBITS+1:0] = snap0+snap1+snap2+snap3.
//   - registered, updated on the DONE_S edge only when no error; reset 0.
//  READER_TOTAL_EN undefined: no total port, no adder. All other behaviour is identical.
// TESTING
//  1 Counts 1,2,3,4 in FIFO0..3, idle=1, start -> req seq idx 3,2,1,0; snap0..3=1,2,3,4; snap_valid=1; done after edge 12.
//  2 Start with idle=0 for 5 cycles, then idle=1 -> req=0 while idle=0; poll then completes with correct snaps.
//  3 Responder never asserts valid_out -> idx=3 requested 3 times, error=1, done pulse, snap_valid=0, snaps unchanged.
//  4 10 more pushes to FIFO0, then second poll -> snap0=11, snap1..3 unchanged; start pulses during busy are ignored.
//  5 reset=0 while in WAIT_S for idx=1 -> all outputs 0 immediately; a new start after release gives a full correct snapshot.
//  6 READER_TOTAL_EN with counts 1,2,3,4 -> total=10 after done; total=0 after reset; total unchanged on an error poll.

Source files
------------

// File: rtl/counter_poll_reader.sv
// Polls the four per-FIFO push counters (idx 3..0) and latches one coherent snapshot.
// Optional READER_TOTAL_EN adds a registered sum of the four snapshots.
module counter_poll_reader #(
   parameter int CBITS     = 5,
   parameter int TIMEOUT   = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             idle,
   input  logic [CBITS-1:0] counter_out,
   input  logic             valid_out,
   output logic             req,
   output logic [1:0]       idx,
   output logic [CBITS-1:0] snap0,
   output logic [CBITS-1:0] snap1,
   output logic [CBITS-1:0] snap2,
   output logic [CBITS-1:0] snap3,
   output logic             snap_valid,
   output logic             busy,
   output logic             done,
   output logic             error
`ifdef READER_TOTAL_EN
   ,
   output logic [CBITS+1:0] total
`endif
);

   localparam logic [1:0] IDLE_S = 2'd0;
   localparam logic [1:0] REQ_S  = 2'd1;
   localparam logic [1:0] WAIT_S = 2'd2;
   localparam logic [1:0] DONE_S = 2'd3;

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   logic [1:0]    state;
   logic [1:0]    cur;
   logic [WW-1:0] wait_cnt;
   logic [RW-1:0] retry_cnt;

   assign busy = (state != IDLE_S);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE_S;
         cur        <= 2'd0;
         wait_cnt   <= '0;
         retry_cnt  <= '0;
         req        <= 1'b0;
         idx        <= 2'd0;
         snap0      <= '0;
         snap1      <= '0;
         snap2      <= '0;
         snap3      <= '0;
         snap_valid <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef READER_TOTAL_EN
         total      <= '0;
`endif
      end else begin
         req  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE_S: begin
               if (start) begin
                  state      <= REQ_S;
                  cur        <= 2'd3;
                  snap_valid <= 1'b0;
                  error      <= 1'b0;
                  retry_cnt  <= '0;
               end
            end
            REQ_S: begin
               if (idle) begin
                  req      <= 1'b1;
                  idx      <= cur;
                  wait_cnt <= '0;
                  state    <= WAIT_S;
               end
            end
            WAIT_S: begin
               if (valid_out) begin
                  case (cur)
                     2'd0:    snap0 <= counter_out;
                     2'd1:    snap1 <= counter_out;
                     2'd2:    snap2 <= counter_out;
                     default: snap3 <= counter_out;
                  endcase
                  retry_cnt <= '0;
                  if (cur == 2'd0) begin
                     state <= DONE_S;
                     done  <= 1'b1;
                  end else begin
                     cur   <= cur - 2'd1;
                     state <= REQ_S;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  // Timed out: retry this index, or give up once retries are spent.
                  wait_cnt <= '0;
                  if (retry_cnt == RETRY_MAX) begin
                     error <= 1'b1;
                     state <= DONE_S;
                     done  <= 1'b1;
                  end else begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= REQ_S;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE_S: begin
               snap_valid <= !error;
`ifdef READER_TOTAL_EN
               if (!error)
                  total <= {2'b00, snap0} + {2'b00, snap1} + {2'b00, snap2} + {2'b00, snap3};
`endif
               state <= IDLE_S;
            end
            default: state <= IDLE_S;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_poll_reader.sv
// Self-checking bench for counter_poll_reader: a registered responder model plus
// a scoreboard of expected request indices and expected snapshot results.
module tb_counter_poll_reader;
   localparam int CBITS = 5;

   typedef struct packed {
      logic [3:0][CBITS-1:0] s;
      logic                  err;
   } res_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             idle;
   logic [CBITS-1:0] counter_out = '0;
   logic             valid_out = 1'b0;
   logic             req;
   logic [1:0]       idx;
   logic [CBITS-1:0] snap0, snap1, snap2, snap3;
   logic             snap_valid, busy, done, error;
`ifdef READER_TOTAL_EN
   logic [CBITS+1:0] total;
`endif

   int checks = 0;
   int errors = 0;

   logic [1:0]       exp_idx_q[$];
   res_t             exp_res_q[$];
   logic [CBITS-1:0] cnt[4];
   logic [CBITS-1:0] sn[4];
   logic             respond_en;

   counter_poll_reader dut (
      .clk(clk), .reset(reset), .start(start), .idle(idle),
      .counter_out(counter_out), .valid_out(valid_out),
      .req(req), .idx(idx),
      .snap0(snap0), .snap1(snap1), .snap2(snap2), .snap3(snap3),
      .snap_valid(snap_valid), .busy(busy), .done(done), .error(error)
`ifdef READER_TOTAL_EN
      , .total(total)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counter block model: registers its reply on the edge that samples req.
   always @(posedge clk) begin
      if (respond_en && req) begin
         valid_out   <= 1'b1;
         counter_out <= cnt[idx];
      end else begin
         valid_out   <= 1'b0;
         counter_out <= '0;
      end
   end

   res_t r;
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (req === 1'b1) begin
            if (exp_idx_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
            else check("req_idx", 32'(idx), 32'(exp_idx_q.pop_front()));
         end
         if (done === 1'b1) begin
            if (exp_res_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
               r = exp_res_q.pop_front();
               check("snap0", 32'(snap0), 32'(r.s[0]));
               check("snap1", 32'(snap1), 32'(r.s[1]));
               check("snap2", 32'(snap2), 32'(r.s[2]));
               check("snap3", 32'(snap3), 32'(r.s[3]));
               check("error_at_done", 32'(error), 32'(r.err));
            end
         end
      end
   end

   task automatic push_poll(input bit ok);
      res_t e;
      if (ok) begin
         for (int i = 3; i >= 0; i--) exp_idx_q.push_back(2'(i));
         for (int i = 0; i < 4; i++) sn[i] = cnt[i];
      end else begin
         for (int i = 0; i < 3; i++) exp_idx_q.push_back(2'd3);
      end
      for (int i = 0; i < 4; i++) e.s[i] = sn[i];
      e.err = !ok;
      exp_res_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 300) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done === 1'b1) return;
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_after_done(input logic exp_sv, input logic exp_err);
      @(posedge clk);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("snap_valid", 32'(snap_valid), 32'(exp_sv));
      check("error_sticky", 32'(error), 32'(exp_err));
   endtask

   initial begin
      int n;
      reset      = 1'b0;
      start      = 1'b0;
      idle       = 1'b1;
      respond_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = CBITS'(i + 1);
         sn[i]  = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_req", 32'(req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_snaps", 32'({snap0, snap1, snap2, snap3}), 32'd0);
      check("rst_flags", 32'({snap_valid, done, error, idx}), 32'd0);
      @(negedge clk) reset = 1'b1;

      // Basic poll, latency, and start coincident with DONE_S.
      push_poll(1'b1);
      pulse_start();
      wait_done(n);
      check("t1_latency", 32'(n), 32'd12);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      check("t1_busy_edge13", 32'(busy), 32'd0);
      check("t1_snap_valid", 32'(snap_valid), 32'd1);
`ifdef READER_TOTAL_EN
      check("t1_total", 32'(total), 32'd10);
`endif
      repeat (20) @(negedge clk);
      check("t1_stays_idle", 32'(busy), 32'd0);

      // Idle held low: no request until the system goes idle.
      idle = 1'b0;
      push_poll(1'b1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_req_held", 32'(req), 32'd0);
      end
      idle = 1'b1;
      wait_done(n);
      check("t2_latency", 32'(n), 32'd12);
      check_after_done(1'b1, 1'b0);

      // Responder silent: three requests for idx 3, then error.
      respond_en = 1'b0;
      push_poll(1'b0);
      pulse_start();
      wait_done(n);
      check("t3_latency", 32'(n), 32'd15);
      check_after_done(1'b0, 1'b1);
      repeat (5) @(negedge clk);
      check("t3_error_hold", 32'(error), 32'd1);
      check("t3_snaps_kept", 32'({snap3, snap2, snap1, snap0}), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
`ifdef READER_TOTAL_EN
      check("t3_total", 32'(total), 32'd10);
`endif

      // More pushes to FIFO0; a start pulse while busy is ignored.
      respond_en = 1'b1;
      cnt[0] = cnt[0] + CBITS'(10);
      push_poll(1'b1);
      pulse_start();
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(n);
      check_after_done(1'b1, 1'b0);
      check("t4_snap0", 32'(snap0), 32'd11);
`ifdef READER_TOTAL_EN
      check("t4_total", 32'(total), 32'd20);
`endif
      repeat (20) @(negedge clk);
      check("t4_stays_idle", 32'(busy), 32'd0);

      // Reset while waiting on idx 1.
      push_poll(1'b1);
      pulse_start();
      n = 0;
      while (n < 100 && !(req === 1'b1 && idx == 2'd1)) begin
         @(negedge clk);
         n++;
      end
      check("t5_reached_idx1", 32'(n < 100), 32'd1);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_outs", 32'({req, idx, done, error, snap_valid}), 32'd0);
      check("t5_snaps", 32'({snap0, snap1, snap2, snap3}), 32'd0);
`ifdef READER_TOTAL_EN
      check("t5_total", 32'(total), 32'd0);
`endif
      exp_idx_q.delete();
      exp_res_q.delete();
      for (int i = 0; i < 4; i++) sn[i] = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      push_poll(1'b1);
      pulse_start();
      wait_done(n);
      check("t5_latency", 32'(n), 32'd12);
      check_after_done(1'b1, 1'b0);
`ifdef READER_TOTAL_EN
      check("t5_total_after", 32'(total), 32'd20);
`endif

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(exp_idx_q.size() + exp_res_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
